// File: rtl/teclado_cajero_if.sv
// Signal bundle between the ATM keypad matrix and the keypad decoder.
// The keypad side drives the raw key level, key code and entry mode; the
// decoder side returns the accepted digit, committed amount and flags.
interface teclado_cajero_if;
   logic        TECLA_VALIDA;
   logic [3:0]  TECLA;
   logic        MODO;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB;
   logic [31:0] MONTO;
   logic        MONTO_STB;
   logic        DESBORDE;

   // Keypad / stimulus side
   modport master (
      output TECLA_VALIDA, TECLA, MODO,
      input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
   );

   // Decoder side
   modport slave (
      input  TECLA_VALIDA, TECLA, MODO,
      output DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
   );
endinterface

// File: rtl/teclado_cajero.sv
// ATM keypad decoder: debounces a raw key level, then either emits PIN
// digits one at a time or accumulates a 32-bit decimal amount that is
// committed with ENTER. Overflowing the amount raises DESBORDE until the
// entry is cleared by ENTER, BORRAR or a change of entry mode.
module teclado_cajero #(
   parameter int unsigned N_ANTIRREBOTE = 4
) (
   input  logic              clk,
   input  logic              rst,
   teclado_cajero_if.slave   bus
);

   localparam logic [7:0] N_CNT = 8'(N_ANTIRREBOTE);

   localparam logic [3:0] COD_ENTER  = 4'hA;
   localparam logic [3:0] COD_BORRAR = 4'hB;

   typedef enum logic [1:0] {
      REPOSO,
      FILTRA_PULSO,
      SOSTENIDA,
      FILTRA_SUELTA
   } estado_t;

   estado_t     estado_q, estado_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  codigo_q, codigo_d;
   logic        acepta;

   logic        modo_prev_q;
   logic [31:0] acc_q, acc_d;
   logic        desb_q, desb_d;
   logic [3:0]  digito_q, digito_d;
   logic        dstb_q, dstb_d;
   logic [31:0] monto_q, monto_d;
   logic        mstb_q, mstb_d;

   logic        cambio_modo;
   logic [31:0] acc_base;
   logic        desb_base;
   logic [35:0] candidato;

   // Debounce state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado_q <= REPOSO;
         cnt_q    <= '0;
         codigo_q <= '0;
      end else begin
         estado_q <= estado_d;
         cnt_q    <= cnt_d;
         codigo_q <= codigo_d;
      end
   end

   // Debounce next state: a press is accepted on the sample that makes the
   // run of identical codes N long; a release needs N low samples too.
   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      codigo_d = codigo_q;
      acepta   = 1'b0;
      unique case (estado_q)
         REPOSO: begin
            if (bus.TECLA_VALIDA) begin
               codigo_d = bus.TECLA;
               cnt_d    = 8'd1;
               estado_d = FILTRA_PULSO;
            end
         end
         FILTRA_PULSO: begin
            if (!bus.TECLA_VALIDA) begin
               cnt_d    = '0;
               estado_d = REPOSO;
            end else if (bus.TECLA != codigo_q) begin
               // Code bounced to a different key: restart the run on it
               codigo_d = bus.TECLA;
               cnt_d    = 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == N_CNT) begin
                  acepta   = 1'b1;
                  estado_d = SOSTENIDA;
               end
            end
         end
         SOSTENIDA: begin
            if (!bus.TECLA_VALIDA) begin
               cnt_d    = 8'd1;
               estado_d = FILTRA_SUELTA;
            end
         end
         FILTRA_SUELTA: begin
            if (bus.TECLA_VALIDA) begin
               estado_d = SOSTENIDA;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == N_CNT) begin
                  cnt_d    = '0;
                  estado_d = REPOSO;
               end
            end
         end
         default: estado_d = REPOSO;
      endcase
   end

   // Key action: a mode change wipes the entry first, then the accepted key
   // (if any) is applied under the current mode.
   always_comb begin
      cambio_modo = (bus.MODO != modo_prev_q);
      acc_base    = cambio_modo ? 32'd0 : acc_q;
      desb_base   = cambio_modo ? 1'b0  : desb_q;
      candidato   = ({4'd0, acc_base} << 3) + ({4'd0, acc_base} << 1)
                    + {32'd0, codigo_q};

      acc_d    = acc_base;
      desb_d   = desb_base;
      digito_d = digito_q;
      dstb_d   = 1'b0;
      monto_d  = monto_q;
      mstb_d   = 1'b0;

      if (acepta) begin
         if (!bus.MODO) begin
            if (codigo_q < 4'd10) begin
               digito_d = codigo_q;
               dstb_d   = 1'b1;
            end
         end else if (codigo_q < 4'd10) begin
            if (!desb_base) begin
               if (candidato[35:32] == 4'd0) begin
                  acc_d = candidato[31:0];
               end else begin
                  desb_d = 1'b1;
               end
            end
         end else if (codigo_q == COD_ENTER) begin
            if (!desb_base) begin
               monto_d = acc_base;
               mstb_d  = 1'b1;
            end
            acc_d  = '0;
            desb_d = 1'b0;
         end else if (codigo_q == COD_BORRAR) begin
            acc_d  = '0;
            desb_d = 1'b0;
         end
      end
   end

   // Entry datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         modo_prev_q <= 1'b0;
         acc_q       <= '0;
         desb_q      <= 1'b0;
         digito_q    <= '0;
         dstb_q      <= 1'b0;
         monto_q     <= '0;
         mstb_q      <= 1'b0;
      end else begin
         modo_prev_q <= bus.MODO;
         acc_q       <= acc_d;
         desb_q      <= desb_d;
         digito_q    <= digito_d;
         dstb_q      <= dstb_d;
         monto_q     <= monto_d;
         mstb_q      <= mstb_d;
      end
   end

   assign bus.DIGITO     = digito_q;
   assign bus.DIGITO_STB = dstb_q;
   assign bus.MONTO      = monto_q;
   assign bus.MONTO_STB  = mstb_q;
   assign bus.DESBORDE   = desb_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Bench for teclado_cajero: a table of clean key presses with expected
// outputs, hand sequences for bounce, relatch, mode/accept coincidence and
// mid-filter reset, then random presses against an arithmetic model.
module tb_teclado_cajero;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   teclado_cajero_if bus ();

   teclado_cajero #(.N_ANTIRREBOTE(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int   cyc;
   int   dstb_n, mstb_n, dstb_first, mstb_first;
   logic prev_d = 1'b0;
   logic prev_m = 1'b0;

   typedef struct {
      logic        m;
      logic [3:0]  k;
      int          hold;
      int          rel;
      int          e_d;
      logic [3:0]  e_dig;
      int          e_m;
      logic [31:0] e_monto;
      logic        e_desb;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One clock: sample 1 ns after the rising edge, track strobes
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.DIGITO_STB === 1'b1) begin
         chk("dstb_back_to_back", {31'd0, prev_d}, 32'd0);
         dstb_n++;
         if (dstb_first < 0) dstb_first = cyc;
      end
      if (bus.MONTO_STB === 1'b1) begin
         chk("mstb_back_to_back", {31'd0, prev_m}, 32'd0);
         mstb_n++;
         if (mstb_first < 0) mstb_first = cyc;
      end
      prev_d = bus.DIGITO_STB;
      prev_m = bus.MONTO_STB;
   endtask

   task automatic clr_win();
      cyc        = 0;
      dstb_n     = 0;
      mstb_n     = 0;
      dstb_first = -1;
      mstb_first = -1;
   endtask

   task automatic press(input logic m, input logic [3:0] k, input int hold, input int rel);
      clr_win();
      bus.MODO         = m;
      bus.TECLA        = k;
      bus.TECLA_VALIDA = 1'b1;
      repeat (hold) tick();
      bus.TECLA_VALIDA = 1'b0;
      repeat (rel) tick();
   endtask

   task automatic verify(input string tag, input int e_d, input logic [3:0] e_dig,
                         input int e_m, input logic [31:0] e_monto, input logic e_desb);
      chk({tag, ".dstb_count"}, dstb_n, e_d);
      chk({tag, ".digito"}, {28'd0, bus.DIGITO}, {28'd0, e_dig});
      chk({tag, ".mstb_count"}, mstb_n, e_m);
      chk({tag, ".monto"}, bus.MONTO, e_monto);
      chk({tag, ".desborde"}, {31'd0, bus.DESBORDE}, {31'd0, e_desb});
      if (e_d > 0) chk({tag, ".dstb_latency"}, dstb_first, N);
      if (e_m > 0) chk({tag, ".mstb_latency"}, mstb_first, N);
   endtask

   function automatic void add(input logic m, input logic [3:0] k, input int hold, input int rel,
                               input int e_d, input logic [3:0] e_dig, input int e_m,
                               input logic [31:0] e_monto, input logic e_desb);
      vec_t v;
      v.m = m; v.k = k; v.hold = hold; v.rel = rel;
      v.e_d = e_d; v.e_dig = e_dig; v.e_m = e_m; v.e_monto = e_monto; v.e_desb = e_desb;
      tbl.push_back(v);
   endfunction

   // Reference model state
   logic        r_mode;
   longint      r_acc;
   logic        r_desb;
   logic [31:0] r_monto;
   logic [3:0]  r_dig;

   initial begin
      int pin[4]  = '{3, 7, 6, 1};
      int big[10] = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};

      bus.TECLA_VALIDA = 1'b0;
      bus.TECLA        = 4'd0;
      bus.MODO         = 1'b0;
      clr_win();

      // Reset state
      tick();
      tick();
      chk("reset.digito", {28'd0, bus.DIGITO}, 32'd0);
      chk("reset.dstb", {31'd0, bus.DIGITO_STB}, 32'd0);
      chk("reset.monto", bus.MONTO, 32'd0);
      chk("reset.mstb", {31'd0, bus.MONTO_STB}, 32'd0);
      chk("reset.desborde", {31'd0, bus.DESBORDE}, 32'd0);
      rst = 1'b1;
      tick();

      // Table of clean presses
      for (int i = 0; i < 4; i++) add(1'b0, 4'(pin[i]), 6, 6, 1, 4'(pin[i]), 0, 32'd0, 1'b0);
      add(1'b1, 4'd1, 6, 6, 0, 4'd1, 0, 32'd0, 1'b0);
      add(1'b1, 4'd2, 6, 6, 0, 4'd1, 0, 32'd0, 1'b0);
      add(1'b1, 4'd5, 6, 6, 0, 4'd1, 0, 32'd0, 1'b0);
      add(1'b1, 4'd0, 6, 6, 0, 4'd1, 0, 32'd0, 1'b0);
      add(1'b1, 4'hA, 6, 6, 0, 4'd1, 1, 32'd1250, 1'b0);
      for (int i = 0; i < 10; i++) add(1'b1, 4'(big[i]), 6, 6, 0, 4'd1, 0, 32'd1250, 1'b0);
      add(1'b1, 4'hA, 6, 6, 0, 4'd1, 1, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 10; i++) add(1'b1, 4'(big[i]), 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b0);
      add(1'b1, 4'd0, 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b1);
      add(1'b1, 4'd3, 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b1);
      add(1'b1, 4'hA, 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b0);
      add(1'b1, 4'd7, 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b0);
      add(1'b1, 4'hB, 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b0);
      add(1'b1, 4'hC, 6, 6, 0, 4'd1, 0, 32'hFFFF_FFFF, 1'b0);
      add(1'b1, 4'hA, 6, 6, 0, 4'd1, 1, 32'd0, 1'b0);
      add(1'b0, 4'hA, 6, 6, 0, 4'd1, 0, 32'd0, 1'b0);
      add(1'b0, 4'd8, 50, 6, 1, 4'd8, 0, 32'd0, 1'b0);
      add(1'b0, 4'hF, 6, 6, 0, 4'd8, 0, 32'd0, 1'b0);

      foreach (tbl[i]) begin
         press(tbl[i].m, tbl[i].k, tbl[i].hold, tbl[i].rel);
         verify($sformatf("tbl%0d", i), tbl[i].e_d, tbl[i].e_dig, tbl[i].e_m,
                tbl[i].e_monto, tbl[i].e_desb);
      end

      // Bounce: 2 valid, 1 low, 3 valid, low -> nothing accepted
      clr_win();
      bus.MODO = 1'b0; bus.TECLA = 4'd5; bus.TECLA_VALIDA = 1'b1;
      repeat (2) tick();
      bus.TECLA_VALIDA = 1'b0; tick();
      bus.TECLA_VALIDA = 1'b1; repeat (3) tick();
      bus.TECLA_VALIDA = 1'b0; repeat (6) tick();
      verify("bounce", 0, 4'd8, 0, 32'd0, 1'b0);

      // Code changes mid-filter: run restarts on the new code
      clr_win();
      bus.TECLA = 4'd2; bus.TECLA_VALIDA = 1'b1;
      repeat (2) tick();
      bus.TECLA = 4'd3; repeat (4) tick();
      bus.TECLA_VALIDA = 1'b0; repeat (6) tick();
      chk("relatch.dstb_count", dstb_n, 1);
      chk("relatch.digito", {28'd0, bus.DIGITO}, 32'd3);
      chk("relatch.dstb_latency", dstb_first, 6);

      // Mode change on the acceptance edge: clear first, key under new mode
      press(1'b1, 4'd1, 6, 6);
      press(1'b1, 4'd2, 6, 6);
      clr_win();
      bus.MODO = 1'b1; bus.TECLA = 4'd7; bus.TECLA_VALIDA = 1'b1;
      repeat (N - 1) tick();
      bus.MODO = 1'b0; repeat (3) tick();
      bus.TECLA_VALIDA = 1'b0; repeat (6) tick();
      verify("coinc_to_pin", 1, 4'd7, 0, 32'd0, 1'b0);
      clr_win();
      bus.MODO = 1'b0; bus.TECLA = 4'd3; bus.TECLA_VALIDA = 1'b1;
      repeat (N - 1) tick();
      bus.MODO = 1'b1; repeat (3) tick();
      bus.TECLA_VALIDA = 1'b0; repeat (6) tick();
      verify("coinc_to_amount", 0, 4'd7, 0, 32'd0, 1'b0);
      press(1'b1, 4'hA, 6, 6);
      verify("coinc_enter", 0, 4'd7, 1, 32'd3, 1'b0);

      // Reset in the middle of FILTRA_PULSO with the key still held
      clr_win();
      bus.MODO = 1'b0; bus.TECLA = 4'd9; bus.TECLA_VALIDA = 1'b1;
      repeat (2) tick();
      #2 rst = 1'b0;
      #1;
      chk("rst_mid.digito", {28'd0, bus.DIGITO}, 32'd0);
      chk("rst_mid.monto", bus.MONTO, 32'd0);
      chk("rst_mid.dstb", {31'd0, bus.DIGITO_STB}, 32'd0);
      chk("rst_mid.mstb", {31'd0, bus.MONTO_STB}, 32'd0);
      chk("rst_mid.desborde", {31'd0, bus.DESBORDE}, 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      clr_win();
      repeat (N + 3) tick();
      bus.TECLA_VALIDA = 1'b0; repeat (6) tick();
      verify("rst_mid_after", 1, 4'd9, 0, 32'd0, 1'b0);

      // Random presses against the arithmetic model
      r_mode = 1'b0; r_acc = 0; r_desb = 1'b0; r_monto = 32'd0; r_dig = 4'd9;
      begin
         logic m;
         m = 1'b1;
         for (int t = 0; t < 120; t++) begin
            logic [3:0] k;
            int r, e_d, e_m;
            if ($urandom_range(0, 9) == 0) m = ~m;
            r = $urandom_range(0, 29);
            if (r < 24)       k = ($urandom_range(0, 1) == 1) ? 4'd9 : 4'($urandom_range(0, 9));
            else if (r < 26)  k = 4'hA;
            else if (r == 26) k = 4'hB;
            else              k = 4'($urandom_range(12, 15));

            // Optional short glitch that must not be accepted
            if ($urandom_range(0, 3) == 0) begin
               bus.MODO = m;
               bus.TECLA = 4'($urandom_range(0, 15));
               bus.TECLA_VALIDA = 1'b1;
               repeat ($urandom_range(1, N - 1)) tick();
               bus.TECLA_VALIDA = 1'b0;
               tick();
            end

            // Model
            e_d = 0; e_m = 0;
            if (m != r_mode) begin
               r_mode = m; r_acc = 0; r_desb = 1'b0;
            end
            if (!m) begin
               if (k <= 4'd9) begin r_dig = k; e_d = 1; end
            end else if (k <= 4'd9) begin
               if (!r_desb) begin
                  if (r_acc * 10 + longint'(k) > 64'd4294967295) r_desb = 1'b1;
                  else r_acc = r_acc * 10 + longint'(k);
               end
            end else if (k == 4'hA) begin
               if (!r_desb) begin r_monto = 32'(r_acc); e_m = 1; end
               r_acc = 0; r_desb = 1'b0;
            end else if (k == 4'hB) begin
               r_acc = 0; r_desb = 1'b0;
            end

            press(m, k, $urandom_range(N, N + 5), $urandom_range(N, N + 3));
            verify($sformatf("rnd%0d_k%0d_m%0d", t, k, m), e_d, r_dig, e_m, r_monto, r_desb);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
